// File: rtl/ttl_74356.sv
// Registered, parametrised data selector with channel scanning (clocked 8-input mux successor).
// Optional macro TTL_74356_TRISTATE_EN adds Output_enable_bar, which floats Y, Y_bar and Last.
module ttl_74356 #(
    parameter int WIDTH_IN     = 8,
    parameter int WIDTH_SELECT = $clog2(WIDTH_IN),
    parameter int DELAY_RISE   = 0,
    parameter int DELAY_FALL   = 0
) (
    input  logic                    Clk,
    input  logic                    Clear_bar,
    input  logic                    Enable_bar,
    input  logic                    Load_data_bar,
    input  logic                    Load_select_bar,
    input  logic                    Scan,
`ifdef TTL_74356_TRISTATE_EN
    input  logic                    Output_enable_bar,
`endif
    input  logic [WIDTH_SELECT-1:0] Select,
    input  logic [WIDTH_IN-1:0]     D,
    output logic                    Y,
    output logic                    Y_bar,
    output logic                    Last,
    output logic [WIDTH_SELECT-1:0] Channel
);

    localparam logic [WIDTH_SELECT-1:0] LAST_IDX  = WIDTH_SELECT'(WIDTH_IN - 1);
    localparam logic [WIDTH_SELECT:0]   SEL_LIMIT = (WIDTH_SELECT + 1)'(WIDTH_IN);
    localparam logic [WIDTH_SELECT-1:0] SEL_ONE   = WIDTH_SELECT'(1);

    // The delay parameters exist for pin compatibility with the timed library
    // models; the synthesised part carries no modelled delay.
    generate
        if (WIDTH_IN < 2) begin : g_bad_width
            $error("ttl_74356: WIDTH_IN must be at least 2");
        end
        if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
            $error("ttl_74356: delays must be non-negative");
        end
    endgenerate

    logic [WIDTH_IN-1:0]     dr_reg;
    logic [WIDTH_IN-1:0]     dr_next;
    logic [WIDTH_SELECT-1:0] sr_reg;
    logic [WIDTH_SELECT-1:0] sr_next;
    logic                    select_ok;
    logic                    sr_at_last;
    logic [WIDTH_IN-1:0]     sel_hit;
    logic                    data_bit;
    logic                    computed;
    logic                    last_int;

    // Out-of-range indices (possible when WIDTH_IN is not a power of two) load as channel 0.
    assign select_ok  = ({1'b0, Select} < SEL_LIMIT);
    assign sr_at_last = (sr_reg == LAST_IDX);

    always_comb begin
        dr_next = dr_reg;
        if (!Load_data_bar) begin
            dr_next = D;
        end
    end

    always_comb begin
        sr_next = sr_reg;
        if (!Load_select_bar) begin
            sr_next = select_ok ? Select : '0;
        end else if (Scan && !Enable_bar) begin
            sr_next = sr_at_last ? '0 : (sr_reg + SEL_ONE);
        end
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            dr_reg <= '0;
            sr_reg <= '0;
        end else begin
            dr_reg <= dr_next;
            sr_reg <= sr_next;
        end
    end

    // One-hot decode of the select register keeps the mux valid for non power-of-two widths.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH_IN; gi++) begin : g_hit
            assign sel_hit[gi] = (sr_reg == WIDTH_SELECT'(gi));
        end
    endgenerate

    assign data_bit = |(dr_reg & sel_hit);
    assign computed = ~Enable_bar & data_bit;
    assign last_int = ~Enable_bar & sr_at_last;
    assign Channel  = sr_reg;

`ifdef TTL_74356_TRISTATE_EN
    assign Y     = Output_enable_bar ? 1'bz : computed;
    assign Y_bar = Output_enable_bar ? 1'bz : ~computed;
    assign Last  = Output_enable_bar ? 1'bz : last_int;
`else
    assign Y     = computed;
    assign Y_bar = ~computed;
    assign Last  = last_int;
`endif

endmodule

// File: tb/tb_ttl_74356.sv
// Directed bench for ttl_74356: an 8-channel and a 5-channel instance driven side by side.
// Define TTL_74356_TRISTATE_EN for both files to exercise the output-enable feature.
module tb_ttl_74356;

    logic clk;
    int   total;
    int   bad;

    // 8-channel instance
    logic       a_clr, a_en, a_ld, a_lsb, a_scan, a_oe;
    logic [2:0] a_sel;
    logic [7:0] a_d;
    logic       a_y, a_y_bar, a_last;
    logic [2:0] a_ch;

    // 5-channel instance
    logic       b_clr, b_en, b_ld, b_lsb, b_scan, b_oe;
    logic [2:0] b_sel;
    logic [4:0] b_d;
    logic       b_y, b_y_bar, b_last;
    logic [2:0] b_ch;

    ttl_74356 #(.WIDTH_IN(8)) u_dut8 (
        .Clk(clk), .Clear_bar(a_clr), .Enable_bar(a_en), .Load_data_bar(a_ld),
        .Load_select_bar(a_lsb), .Scan(a_scan),
`ifdef TTL_74356_TRISTATE_EN
        .Output_enable_bar(a_oe),
`endif
        .Select(a_sel), .D(a_d), .Y(a_y), .Y_bar(a_y_bar), .Last(a_last), .Channel(a_ch)
    );

    ttl_74356 #(.WIDTH_IN(5)) u_dut5 (
        .Clk(clk), .Clear_bar(b_clr), .Enable_bar(b_en), .Load_data_bar(b_ld),
        .Load_select_bar(b_lsb), .Scan(b_scan),
`ifdef TTL_74356_TRISTATE_EN
        .Output_enable_bar(b_oe),
`endif
        .Select(b_sel), .D(b_d), .Y(b_y), .Y_bar(b_y_bar), .Last(b_last), .Channel(b_ch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_clr = 0; a_en = 0; a_ld = 0; a_lsb = 0; a_scan = 1; a_sel = 3'd5; a_d = 8'hFF; a_oe = 0;
        b_clr = 0; b_en = 0; b_ld = 0; b_lsb = 0; b_scan = 1; b_sel = 3'd3; b_d = 5'h1F; b_oe = 0;
        tick();
        tick();
        total++;
        if ({a_y, a_y_bar, a_last, a_ch} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_a got=%b want=%b", {a_y, a_y_bar, a_last, a_ch}, 6'b010000);
        end
        total++;
        if ({b_y, b_y_bar, b_last, b_ch} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_b got=%b want=%b", {b_y, b_y_bar, b_last, b_ch}, 6'b010000);
        end
        a_ld = 1; a_lsb = 1; a_scan = 0;
        b_ld = 1; b_lsb = 1; b_scan = 0;
        a_clr = 1; b_clr = 1;
        #2;
        total++;
        if ({a_y, a_y_bar, a_last, a_ch} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", {a_y, a_y_bar, a_last, a_ch}, 6'b010000);
        end
        $display("reset: a=%b b=%b", {a_y, a_y_bar, a_last, a_ch}, {b_y, b_y_bar, b_last, b_ch});
    endtask

    task automatic test_registered_select();
        a_ld = 0; a_d = 8'b1010_0110; a_lsb = 0; a_sel = 3'd2; a_scan = 0; a_en = 0;
        #1;
        total++;
        if (a_y !== 1'b0) begin
            bad++;
            $display("FAIL sel2_before_edge got=%b want=%b", a_y, 1'b0);
        end
        tick();
        total++;
        if ({a_y, a_y_bar, a_ch} !== {1'b1, 1'b0, 3'd2}) begin
            bad++;
            $display("FAIL sel2_after_edge got=%b want=%b", {a_y, a_y_bar, a_ch}, 5'b10010);
        end
        a_ld = 1; a_sel = 3'd3;
        #1;
        total++;
        if (a_y !== 1'b1) begin
            bad++;
            $display("FAIL sel3_before_edge got=%b want=%b", a_y, 1'b1);
        end
        tick();
        total++;
        if ({a_y, a_y_bar, a_ch} !== {1'b0, 1'b1, 3'd3}) begin
            bad++;
            $display("FAIL sel3_after_edge got=%b want=%b", {a_y, a_y_bar, a_ch}, 5'b01011);
        end
        $display("registered_select: y=%b ch=%0d", a_y, a_ch);
    endtask

    task automatic test_simultaneous();
        a_sel = 3'd6; a_lsb = 0;
        tick();
        total++;
        if ({a_y, a_last, a_ch} !== {1'b0, 1'b0, 3'd6}) begin
            bad++;
            $display("FAIL sim_setup got=%b want=%b", {a_y, a_last, a_ch}, 5'b00110);
        end
        a_lsb = 1; a_scan = 1; a_ld = 0; a_d = 8'h80;
        tick();
        total++;
        if ({a_y, a_last, a_ch} !== {1'b1, 1'b1, 3'd7}) begin
            bad++;
            $display("FAIL sim_load_step got=%b want=%b", {a_y, a_last, a_ch}, 5'b11111);
        end
        a_scan = 0; a_ld = 1;
        $display("simultaneous: y=%b last=%b ch=%0d", a_y, a_last, a_ch);
    endtask

    task automatic test_enable_gate();
        a_en = 1;
        #1;
        total++;
        if ({a_y, a_y_bar, a_last, a_ch} !== {1'b0, 1'b1, 1'b0, 3'd7}) begin
            bad++;
            $display("FAIL enable_off got=%b want=%b", {a_y, a_y_bar, a_last, a_ch}, 6'b010111);
        end
        a_en = 0;
        #1;
        total++;
        if ({a_y, a_y_bar, a_last, a_ch} !== {1'b1, 1'b0, 1'b1, 3'd7}) begin
            bad++;
            $display("FAIL enable_on got=%b want=%b", {a_y, a_y_bar, a_last, a_ch}, 6'b101111);
        end
        $display("enable_gate: y=%b last=%b", a_y, a_last);
    endtask

    task automatic test_scan_wrap();
        logic [2:0] exp_ch   [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        logic       exp_y    [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_last [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        b_ld = 0; b_d = 5'b10011; b_lsb = 0; b_sel = 3'd0; b_scan = 0; b_en = 0;
        tick();
        b_ld = 1; b_lsb = 1; b_scan = 1;
        for (int i = 0; i < 7; i++) begin
            total++;
            if ({b_y, b_last, b_ch} !== {exp_y[i], exp_last[i], exp_ch[i]}) begin
                bad++;
                $display("FAIL scan_step%0d got=%b want=%b", i, {b_y, b_last, b_ch},
                         {exp_y[i], exp_last[i], exp_ch[i]});
            end
            $display("scan step %0d: y=%b last=%b ch=%0d", i, b_y, b_last, b_ch);
            tick();
        end
    endtask

    task automatic test_boundaries();
        // scan still on, Sr=2: a load must win over the increment
        b_lsb = 0; b_sel = 3'd4;
        tick();
        total++;
        if (b_ch !== 3'd4) begin
            bad++;
            $display("FAIL load_sel4 got=%0d want=%0d", b_ch, 4);
        end
        b_sel = 3'd5;
        tick();
        total++;
        if (b_ch !== 3'd0) begin
            bad++;
            $display("FAIL load_sel5_oor got=%0d want=%0d", b_ch, 0);
        end
        b_lsb = 1;
        tick();
        b_lsb = 0; b_sel = 3'd7;
        tick();
        total++;
        if (b_ch !== 3'd0) begin
            bad++;
            $display("FAIL load_sel7_oor got=%0d want=%0d", b_ch, 0);
        end
        b_sel = 3'd3;
        tick();
        total++;
        if (b_ch !== 3'd3) begin
            bad++;
            $display("FAIL load_beats_scan got=%0d want=%0d", b_ch, 3);
        end
        b_lsb = 1; b_en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({b_y, b_last, b_ch} !== {1'b0, 1'b0, 3'd3}) begin
                bad++;
                $display("FAIL frozen%0d got=%b want=%b", i, {b_y, b_last, b_ch}, 5'b00011);
            end
        end
        b_en = 0;
        tick();
        total++;
        if ({b_y, b_last, b_ch} !== {1'b1, 1'b1, 3'd4}) begin
            bad++;
            $display("FAIL resume got=%b want=%b", {b_y, b_last, b_ch}, 5'b11100);
        end
        $display("boundaries: ch=%0d y=%b last=%b", b_ch, b_y, b_last);
    endtask

    task automatic test_clear_mid_scan();
        #2;
        b_clr = 0;
        #1;
        total++;
        if ({b_y, b_y_bar, b_last, b_ch} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL clear_async got=%b want=%b", {b_y, b_y_bar, b_last, b_ch}, 6'b010000);
        end
        b_clr = 1;
        tick();
        total++;
        if ({b_y, b_ch} !== {1'b0, 3'd1}) begin
            bad++;
            $display("FAIL clear_first_edge got=%b want=%b", {b_y, b_ch}, 4'b0001);
        end
        b_scan = 0;
        $display("clear_mid_scan: y=%b ch=%0d", b_y, b_ch);
    endtask

`ifdef TTL_74356_TRISTATE_EN
    task automatic test_tristate();
        a_oe = 1; a_scan = 1; a_ld = 0; a_d = 8'hFF;
        #1;
        total++;
        if ({a_y, a_y_bar, a_last} !== 3'bzzz) begin
            bad++;
            $display("FAIL tristate_z got=%b want=zzz", {a_y, a_y_bar, a_last});
        end
        tick();
        a_ld = 1;
        tick();
        total++;
        if ({a_y, a_ch} !== {1'bz, 3'd1}) begin
            bad++;
            $display("FAIL tristate_scan got=%b want=z001", {a_y, a_ch});
        end
        a_scan = 0; a_oe = 0;
        #1;
        total++;
        if ({a_y, a_y_bar, a_last, a_ch} !== {1'b1, 1'b0, 1'b0, 3'd1}) begin
            bad++;
            $display("FAIL tristate_release got=%b want=%b", {a_y, a_y_bar, a_last, a_ch}, 6'b100001);
        end
        $display("tristate: y=%b ch=%0d", a_y, a_ch);
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_registered_select();
        test_simultaneous();
        test_enable_gate();
        test_scan_wrap();
        test_boundaries();
        test_clear_mid_scan();
`ifdef TTL_74356_TRISTATE_EN
        test_tristate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
